// File: rtl/sample_streamer_pkg.sv
// ============================================================================
// Module : sample_streamer_pkg
// Brief  : Shared sample-memory geometry defaults and streamer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sample_streamer_pkg;

    localparam int unsigned DEF_SAMPLE_CNT = 4;
    localparam int unsigned DEF_IN_DIM     = 3;
    localparam int unsigned DEF_IN_ENTRY_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sample_streamer.sv
// ============================================================================
// Module : sample_streamer
// Brief  : Walks the sample memory and presents each vector through a
//          registered valid/ready stage, one vector per clock when unstalled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_streamer
    import sample_streamer_pkg::*;
#(
    parameter int unsigned SAMPLE_CNT = DEF_SAMPLE_CNT,
    parameter int unsigned IN_DIM     = DEF_IN_DIM,
    parameter int unsigned IN_ENTRY_W = DEF_IN_ENTRY_W,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    output logic [31:0]                          mem_addr,
    input  logic [IN_DIM-1:0][IN_ENTRY_W-1:0]    mem_data,
    output logic [IN_DIM-1:0][IN_ENTRY_W-1:0]    out_data,
    output logic [31:0]                          out_index,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ptr;
    logic        room;
    logic        more;
    logic        load;
    logic        finish;

    // The output slot can take a new vector when empty or being drained this cycle.
    assign room   = !out_valid || out_ready;
    assign more   = (ptr < SAMPLE_CNT);
    assign load   = (state == ST_STREAM) && more && room;
    assign finish = (state == ST_STREAM) && !more && room;

    assign mem_addr = BASE_ADDR + ptr;
    assign busy     = (state == ST_STREAM);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start)  state_nxt = ST_STREAM;
            ST_STREAM: if (finish) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 32'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 32'd0;
        end else if (abort) begin
            ptr       <= 32'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_STREAM: begin
                    if (load) begin
                        out_data  <= mem_data;
                        out_index <= ptr;
                        out_valid <= 1'b1;
                        ptr       <= ptr + 32'd1;
                    end else if (room) begin
                        // Nothing left to load: drain the slot once accepted.
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    ptr       <= 32'd0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sample_streamer.sv
// ============================================================================
// Module : tb_sample_streamer
// Brief  : Directed scoreboard bench for sample_streamer (4 samples x 3 entries).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sample_streamer;

    localparam int unsigned N    = 4;
    localparam int unsigned DIM  = 3;
    localparam int unsigned EW   = 16;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     abort;
    logic [31:0]              mem_addr;
    logic [DIM-1:0][EW-1:0]   mem_data;
    logic [DIM-1:0][EW-1:0]   out_data;
    logic [31:0]              out_index;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    sample_streamer #(
        .SAMPLE_CNT (N),
        .IN_DIM     (DIM),
        .IN_ENTRY_W (EW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample memory model: mem[i][j] = 16*i + j
    always_comb begin
        logic [31:0] idx;
        idx = mem_addr - BASE;
        for (int j = 0; j < int'(DIM); j++) begin
            mem_data[j] = EW'(idx * 16 + 32'(j));
        end
    end

    typedef struct {
        logic [31:0] idx;
        logic [47:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_hs = -100;

    function automatic logic [47:0] vec(input int i);
        logic [47:0] v;
        for (int j = 0; j < int'(DIM); j++) begin
            v[j*16 +: 16] = 16'(16 * i + j);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs are already set for the coming edge; sample, then advance one cycle.
    task automatic cycle();
        exp_t e;
        if (out_valid && out_ready) begin
            hs_cnt++;
            last_hs = cyc;
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("hs_index", 64'(out_index), 64'(e.idx));
                chk("hs_data", 64'(out_data), 64'(e.data));
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_after_hs", 64'(cyc - last_hs), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_run();
        exp_t e;
        for (int i = 0; i < int'(N); i++) begin
            e.idx  = 32'(i);
            e.data = vec(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_done();
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && done_cnt == d0; k++) cycle();
        chk("run_timeout", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic wait_index(input int n);
        for (int k = 0; k < 20 && !(out_valid && out_index == 32'(n)); k++) cycle();
        chk("reach_idx", 64'(out_valid && out_index == 32'(n)), 64'd1);
    endtask

    initial begin
        int h0;
        int d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // 1. reset
        cycle(); cycle();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'(BASE));
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        cycle();

        // 2. full-throughput run
        h0 = hs_cnt; d0 = done_cnt;
        out_ready = 1'b1;
        push_run();
        pulse_start();
        chk("lat_busy", 64'(busy), 64'd1);
        chk("lat_valid0", 64'(out_valid), 64'd0);
        cycle();
        chk("lat_valid1", 64'(out_valid), 64'd1);
        chk("lat_index", 64'(out_index), 64'd0);
        run_to_done();
        chk("run_hs", 64'(hs_cnt - h0), 64'(N));
        chk("run_done", 64'(done_cnt - d0), 64'd1);
        chk("run_q_empty", 64'(exp_q.size()), 64'd0);
        chk("run_idle", 64'(busy), 64'd0);
        chk("run_hold_data", 64'(out_data), 64'(vec(N - 1)));
        chk("run_addr", 64'(mem_addr), 64'(BASE));

        // 3. backpressure on index 1
        h0 = hs_cnt;
        push_run();
        pulse_start();
        wait_index(1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_index", 64'(out_index), 64'd1);
            chk("bp_data", 64'(out_data), 64'(vec(1)));
            chk("bp_addr", 64'(mem_addr), 64'(BASE + 32'd2));
            chk("bp_valid", 64'(out_valid), 64'd1);
        end
        run_to_done();
        chk("bp_hs", 64'(hs_cnt - h0), 64'(N));
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // 4. abort at index 2, then replay
        d0 = done_cnt;
        push_run();
        pulse_start();
        wait_index(2);
        out_ready = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("ab_valid", 64'(out_valid), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("ab_no_done", 64'(done_cnt - d0), 64'd0);
        chk("ab_addr", 64'(mem_addr), 64'(BASE));
        exp_q.delete();
        h0 = hs_cnt;
        push_run();
        pulse_start();
        run_to_done();
        chk("replay_hs", 64'(hs_cnt - h0), 64'(N));
        chk("replay_q_empty", 64'(exp_q.size()), 64'd0);

        // 5. start held through STREAM and DONE
        h0 = hs_cnt; d0 = done_cnt;
        push_run();
        out_ready = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 40 && done_cnt == d0; k++) cycle();
        start = 1'b0;
        chk("st_hs", 64'(hs_cnt - h0), 64'(N));
        chk("st_done", 64'(done_cnt - d0), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("st_idle", 64'(busy), 64'd0);
        end
        chk("st_done_once", 64'(done_cnt - d0), 64'd1);

        // 6. mid-cycle reset during STREAM, then abort+start together
        push_run();
        pulse_start();
        wait_index(1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_hold_valid", 64'(out_valid), 64'd1);
        chk("mr_hold_index", 64'(out_index), 64'd1);
        chk("mr_hold_busy", 64'(busy), 64'd1);
        cycle();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_index", 64'(out_index), 64'd0);
        chk("mr_data", 64'(out_data), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_addr", 64'(mem_addr), 64'(BASE));
        exp_q.delete();
        rst = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        chk("as_busy", 64'(busy), 64'd0);
        cycle();
        chk("as_valid", 64'(out_valid), 64'd0);
        chk("as_busy2", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
